// File: rtl/block_lock_ctrl.sv
// block_lock_ctrl: 64b/66b sync-header block-lock FSM that commands aligner slips and tracks lock loss.
module block_lock_ctrl #(
  parameter int LOCK_CNT  = 64,
  parameter int BAD_MAX   = 16,
  parameter int SLIP_WAIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       hdr_valid_i,
  input  logic [1:0] hdr_i,
  input  logic       resync_i,
  output logic       slip_o,
  output logic [6:0] block_offset_o,
  output logic       block_locked_o,
  output logic [7:0] lock_loss_cnt_o
);
  localparam int SW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(BAD_MAX + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);
  localparam logic [SW-1:0] SH_LAST   = SW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(BAD_MAX - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT - 1);
  typedef enum logic [1:0] {S_HUNT, S_WAIT, S_LOCKED} state_t;
  state_t        state_q;
  logic [SW-1:0] sh_q;
  logic [BW-1:0] bad_q;
  logic [WW-1:0] wait_q;
  logic [6:0]    off_q;
  logic [7:0]    loss_q;
  logic          slip_q, locked_q;
  logic          hdr_ok, slip_d, loss_d;
  always_comb begin
    hdr_ok = hdr_i[1] ^ hdr_i[0];
    slip_d = resync_i | (hdr_valid_i & ~hdr_ok &
             ((state_q == S_HUNT) | ((state_q == S_LOCKED) & (bad_q == BAD_LAST))));
    loss_d = slip_d & (state_q == S_LOCKED);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_HUNT;
      sh_q     <= '0;
      bad_q    <= '0;
      wait_q   <= '0;
      off_q    <= '0;
      loss_q   <= '0;
      slip_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      slip_q <= slip_d;
      if (slip_d) begin
        off_q    <= (off_q == 7'd65) ? 7'd0 : off_q + 7'd1;
        sh_q     <= '0;
        bad_q    <= '0;
        wait_q   <= '0;
        locked_q <= 1'b0;
        state_q  <= S_WAIT;
        if (loss_d && loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
      end else if (hdr_valid_i) begin
        case (state_q)
          S_HUNT: begin
            if (sh_q == SH_LAST) begin
              sh_q     <= '0;
              bad_q    <= '0;
              locked_q <= 1'b1;
              state_q  <= S_LOCKED;
            end else begin
              sh_q <= sh_q + SW'(1);
            end
          end
          S_WAIT: begin
            wait_q  <= wait_q + WW'(1);
            state_q <= (wait_q == WAIT_LAST) ? S_HUNT : S_WAIT;
          end
          S_LOCKED: begin
            // Non-slip path: the BAD_MAX-th bad header was already diverted to slip_d above.
            if (sh_q == SH_LAST) begin
              sh_q  <= '0;
              bad_q <= '0;
            end else begin
              sh_q  <= sh_q + SW'(1);
              bad_q <= hdr_ok ? bad_q : bad_q + BW'(1);
            end
          end
          default: state_q <= S_HUNT;
        endcase
      end
    end
  end
  assign slip_o          = slip_q;
  assign block_offset_o  = off_q;
  assign block_locked_o  = locked_q;
  assign lock_loss_cnt_o = loss_q;
endmodule

// File: tb/tb_block_lock_ctrl.sv
// tb_block_lock_ctrl: directed scenario bench for block_lock_ctrl with default parameters.
module tb_block_lock_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       hdr_valid_i = 1'b0;
  logic [1:0] hdr_i = 2'b00;
  logic       resync_i = 1'b0;
  logic       slip_o;
  logic [6:0] block_offset_o;
  logic       block_locked_o;
  logic [7:0] lock_loss_cnt_o;
  int checks = 0;
  int errors = 0;
  int slip_cnt = 0;
  int exp_off = 0;
  int exp_loss = 0;

  block_lock_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .hdr_valid_i(hdr_valid_i), .hdr_i(hdr_i),
    .resync_i(resync_i), .slip_o(slip_o), .block_offset_o(block_offset_o),
    .block_locked_o(block_locked_o), .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) if (slip_o) slip_cnt++;

  // Called at a negedge; consecutive calls give back-to-back strobes.
  task automatic strobe(input logic [1:0] h);
    hdr_valid_i = 1'b1;
    hdr_i = h;
    @(negedge clk_i);
    hdr_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic sync_reset_pulse;
    rst_i = 1'b1;
    idle(2);
    rst_i = 1'b0;
    exp_off = 0;
    exp_loss = 0;
  endtask

  task automatic acquire;
    repeat (16) strobe(2'b00);
    repeat (64) strobe(2'b01);
  endtask

  task automatic test_reset;
    @(negedge clk_i);
    idle(2);
    checks += 4;
    if (slip_o !== 1'b0) begin errors++; $display("FAIL reset_slip: got %b exp 0", slip_o); end
    if (block_offset_o !== 7'd0) begin errors++; $display("FAIL reset_off: got %0d exp 0", block_offset_o); end
    if (block_locked_o !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b exp 0", block_locked_o); end
    if (lock_loss_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_loss: got %0d exp 0", lock_loss_cnt_o); end
    rst_i = 1'b0;
    idle(1);
  endtask

  task automatic test_lock_slow;
    for (int i = 1; i <= 64; i++) begin
      strobe(i[0] ? 2'b10 : 2'b01);
      if (i == 63) begin
        checks++;
        if (block_locked_o !== 1'b0) begin errors++; $display("FAIL slow_early_lock: got %b exp 0", block_locked_o); end
      end
      if (i != 64) idle(7);
    end
    checks += 3;
    if (block_locked_o !== 1'b1) begin errors++; $display("FAIL slow_lock: got %b exp 1", block_locked_o); end
    if (block_offset_o !== 7'd0) begin errors++; $display("FAIL slow_off: got %0d exp 0", block_offset_o); end
    if (slip_cnt !== 0) begin errors++; $display("FAIL slow_slips: got %0d exp 0", slip_cnt); end
  endtask

  task automatic test_hunt_slip;
    int base;
    sync_reset_pulse();
    base = slip_cnt;
    repeat (9) strobe(2'b01);
    strobe(2'b11);
    checks += 3;
    if (slip_o !== 1'b1) begin errors++; $display("FAIL hunt_slip: got %b exp 1", slip_o); end
    if (block_offset_o !== 7'd1) begin errors++; $display("FAIL hunt_off: got %0d exp 1", block_offset_o); end
    if (block_locked_o !== 1'b0) begin errors++; $display("FAIL hunt_lock: got %b exp 0", block_locked_o); end
    repeat (16) strobe(2'b00);
    checks++;
    if (slip_cnt - base !== 1) begin errors++; $display("FAIL hunt_wait_slips: got %0d exp 1", slip_cnt - base); end
    repeat (63) strobe(2'b10);
    checks++;
    if (block_locked_o !== 1'b0) begin errors++; $display("FAIL hunt_early_lock: got %b exp 0", block_locked_o); end
    strobe(2'b10);
    checks += 2;
    if (block_locked_o !== 1'b1) begin errors++; $display("FAIL hunt_relock: got %b exp 1", block_locked_o); end
    if (block_offset_o !== 7'd1) begin errors++; $display("FAIL hunt_lock_off: got %0d exp 1", block_offset_o); end
    exp_off = 1;
  endtask

  task automatic test_locked_window;
    repeat (15) strobe(2'b11);
    repeat (49) strobe(2'b01);
    repeat (15) strobe(2'b00);
    repeat (10) strobe(2'b01);
    checks++;
    if (block_locked_o !== 1'b1) begin errors++; $display("FAIL win_15bad_lock: got %b exp 1", block_locked_o); end
    strobe(2'b11);
    exp_off++; exp_loss++;
    checks += 4;
    if (block_locked_o !== 1'b0) begin errors++; $display("FAIL win_unlock: got %b exp 0", block_locked_o); end
    if (slip_o !== 1'b1) begin errors++; $display("FAIL win_slip: got %b exp 1", slip_o); end
    if (block_offset_o !== 7'(exp_off)) begin errors++; $display("FAIL win_off: got %0d exp %0d", block_offset_o, exp_off); end
    if (lock_loss_cnt_o !== 8'(exp_loss)) begin errors++; $display("FAIL win_loss: got %0d exp %0d", lock_loss_cnt_o, exp_loss); end
  endtask

  task automatic test_priority;
    acquire();
    repeat (48) strobe(2'b10);
    repeat (15) strobe(2'b11);
    checks++;
    if (block_locked_o !== 1'b1) begin errors++; $display("FAIL prio_pre_lock: got %b exp 1", block_locked_o); end
    strobe(2'b00);
    exp_off++; exp_loss++;
    checks += 3;
    if (block_locked_o !== 1'b0) begin errors++; $display("FAIL prio_unlock: got %b exp 0", block_locked_o); end
    if (block_offset_o !== 7'(exp_off)) begin errors++; $display("FAIL prio_off: got %0d exp %0d", block_offset_o, exp_off); end
    if (lock_loss_cnt_o !== 8'(exp_loss)) begin errors++; $display("FAIL prio_loss: got %0d exp %0d", lock_loss_cnt_o, exp_loss); end
  endtask

  task automatic test_resync;
    acquire();
    checks++;
    if (block_locked_o !== 1'b1) begin errors++; $display("FAIL rs_prelock: got %b exp 1", block_locked_o); end
    resync_i = 1'b1; hdr_valid_i = 1'b1; hdr_i = 2'b01;
    @(negedge clk_i);
    resync_i = 1'b0; hdr_valid_i = 1'b0;
    exp_off++; exp_loss++;
    checks += 4;
    if (block_locked_o !== 1'b0) begin errors++; $display("FAIL rs_unlock: got %b exp 0", block_locked_o); end
    if (slip_o !== 1'b1) begin errors++; $display("FAIL rs_slip: got %b exp 1", slip_o); end
    if (block_offset_o !== 7'(exp_off)) begin errors++; $display("FAIL rs_off: got %0d exp %0d", block_offset_o, exp_off); end
    if (lock_loss_cnt_o !== 8'(exp_loss)) begin errors++; $display("FAIL rs_loss: got %0d exp %0d", lock_loss_cnt_o, exp_loss); end
    strobe(2'b11);
    checks += 2;
    if (slip_o !== 1'b0) begin errors++; $display("FAIL rs_wait_ignore: got %b exp 0", slip_o); end
    if (block_offset_o !== 7'(exp_off)) begin errors++; $display("FAIL rs_wait_off: got %0d exp %0d", block_offset_o, exp_off); end
    resync_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      exp_off++;
      checks++;
      if (slip_o !== 1'b1) begin errors++; $display("FAIL rs_hold_slip%0d: got %b exp 1", k, slip_o); end
    end
    resync_i = 1'b0;
    @(negedge clk_i);
    checks += 3;
    if (slip_o !== 1'b0) begin errors++; $display("FAIL rs_hold_end: got %b exp 0", slip_o); end
    if (block_offset_o !== 7'(exp_off)) begin errors++; $display("FAIL rs_hold_off: got %0d exp %0d", block_offset_o, exp_off); end
    if (lock_loss_cnt_o !== 8'(exp_loss)) begin errors++; $display("FAIL rs_hold_loss: got %0d exp %0d", lock_loss_cnt_o, exp_loss); end
  endtask

  task automatic test_async_reset;
    resync_i = 1'b1;
    while (exp_off != 5) begin
      @(negedge clk_i);
      exp_off = (exp_off == 65) ? 0 : exp_off + 1;
    end
    resync_i = 1'b0;
    checks += 3;
    if (block_offset_o !== 7'd5) begin errors++; $display("FAIL ar_pre_off: got %0d exp 5", block_offset_o); end
    if (slip_o !== 1'b1) begin errors++; $display("FAIL ar_pre_slip: got %b exp 1", slip_o); end
    if (lock_loss_cnt_o !== 8'(exp_loss)) begin errors++; $display("FAIL ar_pre_loss: got %0d exp %0d", lock_loss_cnt_o, exp_loss); end
    #2 rst_i = 1'b1;
    #1;
    checks += 4;
    if (slip_o !== 1'b0) begin errors++; $display("FAIL ar_slip: got %b exp 0", slip_o); end
    if (block_offset_o !== 7'd0) begin errors++; $display("FAIL ar_off: got %0d exp 0", block_offset_o); end
    if (block_locked_o !== 1'b0) begin errors++; $display("FAIL ar_lock: got %b exp 0", block_locked_o); end
    if (lock_loss_cnt_o !== 8'd0) begin errors++; $display("FAIL ar_loss: got %0d exp 0", lock_loss_cnt_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_off = 0; exp_loss = 0;
    strobe(2'b00);
    checks += 2;
    if (slip_o !== 1'b1) begin errors++; $display("FAIL ar_hunt_slip: got %b exp 1", slip_o); end
    if (block_offset_o !== 7'd1) begin errors++; $display("FAIL ar_hunt_off: got %0d exp 1", block_offset_o); end
  endtask

  task automatic test_wrap;
    sync_reset_pulse();
    for (int i = 1; i <= 66; i++) begin
      strobe(2'b11);
      exp_off = (i == 66) ? 0 : i;
      checks++;
      if (block_offset_o !== 7'(exp_off)) begin errors++; $display("FAIL wrap_off%0d: got %0d exp %0d", i, block_offset_o, exp_off); end
      repeat (16) strobe(2'b11);
    end
  endtask

  task automatic test_saturate;
    sync_reset_pulse();
    for (int i = 1; i <= 256; i++) begin
      repeat (64) strobe(2'b01);
      resync_i = 1'b1;
      @(negedge clk_i);
      resync_i = 1'b0;
      exp_loss = (exp_loss == 255) ? 255 : exp_loss + 1;
      if (i == 1 || i == 255 || i == 256) begin
        checks++;
        if (lock_loss_cnt_o !== 8'(exp_loss)) begin errors++; $display("FAIL sat_loss%0d: got %0d exp %0d", i, lock_loss_cnt_o, exp_loss); end
      end
      repeat (16) strobe(2'b00);
    end
  endtask

  initial begin
    test_reset();
    test_lock_slow();
    test_hunt_slip();
    test_locked_window();
    test_priority();
    test_resync();
    test_async_reset();
    test_wrap();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/block_lock_ctrl.md
# block_lock_ctrl

Block-lock controller for the 64b/66b RX recovery path. It sits after the gearbox/block_sync datapath and watches the 2-bit sync header of each candidate 66-bit block. It searches for header alignment by commanding slips of the block offset, declares lock after a run of valid headers, and drops lock when too many headers in a window are bad. The block_offset_o output drives the offset select of the block aligner.

## Interface
- LOCK_CNT, default 64: valid headers required to declare lock; also the monitoring window length while locked (≥2).
- BAD_MAX, default 16: invalid headers within one locked window that cause loss of lock (1..LOCK_CNT).
- SLIP_WAIT, default 16: header strobes ignored after each slip, to let the aligner settle (≥1).
- clk_i  input  1  clock; single clock domain.
- rst_i  input  1  reset; asynchronous, active-high.
- hdr_valid_i  input  1  one-cycle strobe: hdr_i holds the sync header of a new candidate block.
- hdr_i  input  2  sync header bits; valid header is 2'b01 or 2'b10.
- resync_i  input  1  force re-acquisition; level, sampled every cycle.
- slip_o  output  1  one-cycle pulse per slip command.
- block_offset_o  output  7  current block offset, 0..65.
- block_locked_o  output  1  block lock achieved.
- lock_loss_cnt_o  output  8  number of lock-loss events; saturates at 255.

## Operation
- A header is valid when hdr_i is 2'b01 or 2'b10. Headers 2'b00 and 2'b11 are invalid.
- Counters:
  - sh_cnt counts headers, width $clog2(LOCK_CNT+1).
  - bad_cnt counts invalid headers, width $clog2(BAD_MAX+1).
  - wait_cnt counts ignored strobes, width $clog2(SLIP_WAIT+1).
- States: HUNT, SLIP_WAIT, LOCKED. Reset state is HUNT.
- HUNT, on each hdr_valid_i:
  - Valid header: sh_cnt++. When sh_cnt reaches LOCK_CNT, go to LOCKED, set block_locked_o, clear sh_cnt and bad_cnt.
  - Invalid header: perform a slip, then go to SLIP_WAIT.
- Slip action:
  - Pulse slip_o.
  - block_offset_o = (block_offset_o == 65) ? 0 : block_offset_o + 1.
  - Clear sh_cnt, bad_cnt and wait_cnt. Clear block_locked_o.
- SLIP_WAIT: each hdr_valid_i increments wait_cnt; header contents are ignored. When wait_cnt reaches SLIP_WAIT, go to HUNT.
- LOCKED, on each hdr_valid_i:
  - sh_cnt++; bad_cnt++ if the header is invalid.
  - If bad_cnt reaches BAD_MAX: lose lock. Increment lock_loss_cnt_o (saturating), perform a slip, go to SLIP_WAIT.
  - Otherwise, if sh_cnt reaches LOCK_CNT: window ends, clear sh_cnt and bad_cnt, stay LOCKED.
  - If the BAD_MAX-th bad header is also the LOCK_CNT-th header of the window, loss of lock takes priority.
- resync_i high in any state:
  - Perform a slip and go to SLIP_WAIT. The header strobe in that cycle is discarded.
  - lock_loss_cnt_o increments only if the state was LOCKED.
  - Holding resync_i high slips every cycle.
- hdr_valid_i low: no counter or state changes (resync_i still acts).

## Timing
- All outputs are registered.
- Reset values: slip_o=0, block_offset_o=0, block_locked_o=0, lock_loss_cnt_o=0; all counters 0; state HUNT.
- rst_i asserted mid-operation clears all outputs asynchronously, without waiting for a clock edge.
- Latency, measured from the edge sampling the triggering strobe:
  - slip_o is high in the following cycle only.
  - block_offset_o updates on the same edge that raises slip_o.
  - block_locked_o rises on the edge sampling the LOCK_CNT-th consecutive valid header.
  - block_locked_o falls on the edge issuing the loss-of-lock slip.
- Back-to-back strobes (hdr_valid_i every cycle) are fully supported with no lost headers.
- Minimum spacing between slips:
  - Without resync_i: SLIP_WAIT+1 strobes.
  - With resync_i: 1 cycle.

## Test plan
- Reset, then 64 valid headers (one strobe every 8 cycles) -> block_locked_o rises 1 cycle after the 64th strobe; block_offset_o=0; slip_o never asserted.
- HUNT, invalid header (2'b11) on the 10th strobe -> slip_o pulses once, block_offset_o=1. Next 16 strobes carrying 2'b00 are ignored. Lock follows after 64 further valid strobes.
- 66 slips, each forced by an invalid header after the wait -> block_offset_o steps 0..65, then wraps to 0 on the 66th slip.
- LOCKED, 15 invalid headers in a 64-strobe window -> stays locked; counters clear at window end. Next window with 16 invalid headers -> unlock on the 16th, slip_o pulses, block_offset_o+1, lock_loss_cnt_o=1.
- LOCKED, resync_i high for one cycle coinciding with a valid hdr_valid_i -> block_locked_o=0, single slip, lock_loss_cnt_o increments, state SLIP_WAIT.
- rst_i asserted asynchronously mid-SLIP_WAIT with block_offset_o=5 -> all outputs 0 before the next clock edge. After release, HUNT resumes from offset 0.
